// File: rtl/serial_compare_sequencer.sv
// Front end for the MSB-first serial comparator: accepts an operand pair, clears the
// comparator, streams both operands one bit per cycle and returns the captured flags.
module serial_compare_sequencer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         ser_clr,
  output logic         ser_valid,
  output logic         ser_a,
  output logic         ser_b,
  input  logic         cmp_less,
  input  logic         cmp_eq,
  input  logic         cmp_greater,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_less,
  output logic         out_eq,
  output logic         out_greater
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_FIRST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(0);
  localparam logic [CW-1:0] CNT_STEP  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [W-1:0]  sh_a_r;
  logic [W-1:0]  sh_b_r;
  logic [CW-1:0] cnt_r;
  logic          less_r;
  logic          eq_r;
  logic          greater_r;
  logic          accept_s;
  logic          last_bit_s;

  assign accept_s   = in_valid & in_ready;
  assign last_bit_s = ser_valid & (cnt_r == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and state-decoded handshake/serial strobes
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    ser_clr   = 1'b0;
    ser_valid = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        ser_clr = 1'b1;
        state_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s = ST_RESULT;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_RESULT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESULT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Operand shift registers and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a_r <= {W{1'b0}};
      sh_b_r <= {W{1'b0}};
      cnt_r  <= CNT_LAST;
    end else if (accept_s) begin
      sh_a_r <= in_a;
      sh_b_r <= in_b;
      cnt_r  <= CNT_FIRST;
    end else if (ser_valid) begin
      sh_a_r <= sh_a_r << 32'd1;
      sh_b_r <= sh_b_r << 32'd1;
      cnt_r  <= cnt_r - CNT_STEP;
    end else begin
      sh_a_r <= sh_a_r;
      sh_b_r <= sh_b_r;
      cnt_r  <= cnt_r;
    end
  end

  // Flags are taken as presented on the last bit; one-hotness is the comparator's business
  always_ff @(posedge clk) begin
    if (rst) begin
      less_r    <= 1'b0;
      eq_r      <= 1'b0;
      greater_r <= 1'b0;
    end else if (last_bit_s) begin
      less_r    <= cmp_less;
      eq_r      <= cmp_eq;
      greater_r <= cmp_greater;
    end else begin
      less_r    <= less_r;
      eq_r      <= eq_r;
      greater_r <= greater_r;
    end
  end

  assign ser_a       = ser_valid & sh_a_r[W-1];
  assign ser_b       = ser_valid & sh_b_r[W-1];
  assign out_less    = less_r;
  assign out_eq      = eq_r;
  assign out_greater = greater_r;

endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Bench for serial_compare_sequencer: W=8 and W=1 instances, each driving a behavioural
// serial comparator, checked against a transaction timeline and an arithmetic reference.
module tb_serial_compare_sequencer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
    logic [2:0]  exp;
  } txn_t;

  logic        clk;
  logic        rst;
  int          cyc;
  bit          mon_en;
  bit          bp_mode;
  logic        rnd_or;
  logic        dir_or      [2];
  logic        in_valid_s  [2];
  logic [31:0] in_a_s      [2];
  logic [31:0] in_b_s      [2];
  logic        in_ready_s  [2];
  logic        ser_clr_s   [2];
  logic        ser_valid_s [2];
  logic        ser_a_s     [2];
  logic        ser_b_s     [2];
  logic        out_valid_s [2];
  logic        out_less_s  [2];
  logic        out_eq_s    [2];
  logic        out_gt_s    [2];
  int          n_vec       [2];
  int          n_fail      [2];
  int          stim_vec;
  int          stim_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    rnd_or = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_or = 1'($urandom_range(0, 1));
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int WW = (gi == 0) ? 8 : 1;
    localparam logic [31:0] MASK = 32'((64'd1 << WW) - 64'd1);

    logic out_ready_g;
    logic cmp_less_g;
    logic cmp_eq_g;
    logic cmp_gt_g;
    logic dec_lt_r;
    logic dec_gt_r;
    txn_t sb[$];
    txn_t t;
    bit   busy;
    bit   zero_chk;
    int   k;
    logic e_sv;
    logic e_ea;
    logic e_eb;

    assign out_ready_g = bp_mode ? rnd_or : dir_or[gi];

    serial_compare_sequencer #(.W(WW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_s[gi]),
      .in_ready   (in_ready_s[gi]),
      .in_a       (in_a_s[gi][WW-1:0]),
      .in_b       (in_b_s[gi][WW-1:0]),
      .ser_clr    (ser_clr_s[gi]),
      .ser_valid  (ser_valid_s[gi]),
      .ser_a      (ser_a_s[gi]),
      .ser_b      (ser_b_s[gi]),
      .cmp_less   (cmp_less_g),
      .cmp_eq     (cmp_eq_g),
      .cmp_greater(cmp_gt_g),
      .out_valid  (out_valid_s[gi]),
      .out_ready  (out_ready_g),
      .out_less   (out_less_s[gi]),
      .out_eq     (out_eq_s[gi]),
      .out_greater(out_gt_s[gi])
    );

    // Serial comparator model: first differing bit decides, reset by rst | ser_clr
    always_ff @(posedge clk) begin
      if (rst || ser_clr_s[gi]) begin
        dec_lt_r <= 1'b0;
        dec_gt_r <= 1'b0;
      end else if (ser_valid_s[gi] && !dec_lt_r && !dec_gt_r) begin
        dec_lt_r <= !ser_a_s[gi] && ser_b_s[gi];
        dec_gt_r <= ser_a_s[gi] && !ser_b_s[gi];
      end
    end
    assign cmp_less_g = dec_lt_r || (!dec_gt_r && ser_valid_s[gi] && !ser_a_s[gi] && ser_b_s[gi]);
    assign cmp_gt_g   = dec_gt_r || (!dec_lt_r && ser_valid_s[gi] && ser_a_s[gi] && !ser_b_s[gi]);
    assign cmp_eq_g   = !cmp_less_g && !cmp_gt_g;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec[gi]++;
      if (got !== want) begin
        n_fail[gi]++;
        $display("FAIL W%0d %s at cycle %0d: got %0h, expected %0h", WW, name, cyc, got, want);
      end
    endtask

    initial begin
      n_vec[gi]  = 0;
      n_fail[gi] = 0;
      zero_chk   = 1'b0;
      forever begin
        @(negedge clk);
        if (mon_en) begin
          busy = (sb.size() != 0);
          if (busy) t = sb[0];
          k    = busy ? (cyc - t.acc) : 0;
          e_sv = busy && (k >= 2) && (k <= WW + 1);
          e_ea = 1'b0;
          e_eb = 1'b0;
          if (e_sv) begin
            e_ea = t.a[WW-1-(k-2)];
            e_eb = t.b[WW-1-(k-2)];
          end
          chk("in_ready", 32'(in_ready_s[gi]), 32'(!busy));
          chk("ser_clr", 32'(ser_clr_s[gi]), 32'(busy && k == 1));
          chk("ser_valid", 32'(ser_valid_s[gi]), 32'(e_sv));
          chk("ser_a", 32'(ser_a_s[gi]), 32'(e_ea));
          chk("ser_b", 32'(ser_b_s[gi]), 32'(e_eb));
          chk("out_valid", 32'(out_valid_s[gi]), 32'(busy && k >= WW + 2));
          if (out_valid_s[gi]) begin
            zero_chk = 1'b0;
            if (!busy) begin
              chk("spurious out_valid", 32'd1, 32'd0);
            end else begin
              chk("flags lt/eq/gt", {29'd0, out_less_s[gi], out_eq_s[gi], out_gt_s[gi]},
                  {29'd0, t.exp});
            end
          end else if (zero_chk) begin
            chk("flags after reset", {29'd0, out_less_s[gi], out_eq_s[gi], out_gt_s[gi]}, 32'd0);
          end
          if (rst) begin
            sb.delete();
            zero_chk = 1'b1;
          end else begin
            if (out_valid_s[gi] && out_ready_g && busy) void'(sb.pop_front());
            if (in_valid_s[gi] && in_ready_s[gi]) begin
              t.a   = in_a_s[gi] & MASK;
              t.b   = in_b_s[gi] & MASK;
              t.acc = cyc;
              t.exp = {t.a < t.b, t.a == t.b, t.a > t.b};
              sb.push_back(t);
            end
          end
        end
      end
    end
  end

  task automatic stim_chk(input string name, input int got, input int want);
    stim_vec++;
    if (got != want) begin
      stim_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b, output int acc);
    int n;
    in_a_s[d]     = a;
    in_b_s[d]     = b;
    in_valid_s[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_s[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s[d]) stim_chk("accept timeout", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_s[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_s[d]) stim_chk("idle timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t1;
    int t2;
    int r;
    logic [31:0] ra;
    logic [31:0] rb;
    stim_vec  = 0;
    stim_fail = 0;
    mon_en    = 1'b0;
    bp_mode   = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dir_or[i]     = 1'b1;
      in_valid_s[i] = 1'b0;
      in_a_s[i]     = 32'd0;
      in_b_s[i]     = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Equal operands, then back-to-back with in_valid held high
    send(0, 32'hA5, 32'hA5, t1);
    wait_idle(0);
    send(0, 32'h80, 32'h7F, t1);
    send(0, 32'h00, 32'h01, t2);
    stim_chk("back-to-back spacing", t2 - t1, 11);
    wait_idle(0);

    // Backpressure: result held while a new pair waits
    dir_or[0] = 1'b0;
    send(0, 32'h33, 32'h44, t1);
    r = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid_s[0] && r < 0) r = cyc;
      if (r >= 0) break;
    end
    stim_chk("backpressure result seen", int'(r >= 0), 1);
    @(posedge clk);
    #1;
    in_a_s[0]     = 32'h5A;
    in_b_s[0]     = 32'h5A;
    in_valid_s[0] = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    dir_or[0] = 1'b1;
    send(0, 32'h5A, 32'h5A, t2);
    stim_chk("accept after backpressure", t2, r + 6);
    wait_idle(0);

    // Reset in the middle of SHIFT, then a fresh pair
    send(0, 32'h3C, 32'hC3, t1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 32'h10, 32'h20, t1);
    wait_idle(0);

    // Single-bit instance
    send(1, 32'd1, 32'd0, t1);
    wait_idle(1);
    send(1, 32'd0, 32'd0, t1);
    wait_idle(1);
    send(1, 32'd0, 32'd1, t1);
    wait_idle(1);

    // Random operands with random result backpressure
    bp_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(0, ra, rb, t1);
    end
    wait_idle(0);
    for (int i = 0; i < 16; i++) begin
      send(1, $urandom, $urandom, t1);
    end
    wait_idle(1);
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec[0] + n_vec[1] + stim_vec, n_fail[0] + n_fail[1] + stim_fail);
    $finish;
  end

endmodule
